// File: rtl/trace_step_loader_if.sv
// Stream-in / step-record-out bundle for trace_step_loader.
// slave is the loader's view; master is the producer/decoder side.
interface trace_step_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic        out_valid;
  logic        out_ready;
  logic [95:0] raw_instr;
  logic [31:0] eax;
  logic [31:0] ebx;
  logic [31:0] ecx;
  logic [31:0] edx;
  logic [31:0] esi;
  logic [31:0] edi;
  logic [31:0] esp;
  logic [31:0] ebp;
  logic        hint1_is_write;
  logic        hint2_is_write;
  logic [31:0] hint1_address;
  logic [31:0] hint1_data;
  logic [31:0] hint2_address;
  logic [31:0] hint2_data;
  logic        err;
  logic [31:0] step_count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, raw_instr,
    output eax, ebx, ecx, edx, esi, edi, esp, ebp,
    output hint1_is_write, hint2_is_write,
    output hint1_address, hint1_data, hint2_address, hint2_data,
    output err, step_count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, raw_instr,
    input  eax, ebx, ecx, edx, esi, edi, esp, ebp,
    input  hint1_is_write, hint2_is_write,
    input  hint1_address, hint1_data, hint2_address, hint2_data,
    input  err, step_count
  );
endinterface

// File: rtl/trace_step_loader.sv
// Deserializes 16-word trace frames into one parallel step record for decode.
// Frame N+1 assembles in a separate buffer while decode still holds frame N.
module trace_step_loader #(
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trace_step_loader_if.slave   bus
);

  localparam logic [0:0] S_HDR  = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  logic [0:0]  r_state;
  logic [3:0]  r_idx;
  logic        r_live;
  logic        r_err;
  logic        r_h1w_asm;
  logic        r_h2w_asm;
  logic [31:0] r_buf [1:14];

  logic        r_out_valid;
  logic [95:0] r_raw;
  logic [31:0] r_gpr [0:7];
  logic        r_h1w;
  logic        r_h2w;
  logic [31:0] r_h1a;
  logic [31:0] r_h1d;
  logic [31:0] r_h2a;
  logic [31:0] r_h2d;
  logic [31:0] r_step_count;

  logic w_last;
  logic w_in_ready;
  logic w_word_xfer;
  logic w_rec_xfer;
  logic w_hdr_ok;
  logic w_load;

  // Only the final word may stall, and only while an unconsumed record is held.
  assign w_last      = (r_state == S_BODY) && (r_idx == 4'd15);
  assign w_in_ready  = r_live && (!w_last || !r_out_valid || bus.out_ready);
  assign w_word_xfer = bus.in_valid && w_in_ready;
  assign w_rec_xfer  = r_out_valid && bus.out_ready;
  assign w_hdr_ok    = (bus.in_data[31:24] == MAGIC) && (bus.in_data[23:2] == 22'd0);
  assign w_load      = w_word_xfer && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_HDR;
      r_idx     <= 4'd0;
      r_live    <= 1'b0;
      r_err     <= 1'b0;
      r_h1w_asm <= 1'b0;
      r_h2w_asm <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_word_xfer) begin
        case (r_state)
          S_HDR: begin
            if (w_hdr_ok) begin
              r_state   <= S_BODY;
              r_idx     <= 4'd1;
              r_h1w_asm <= bus.in_data[0];
              r_h2w_asm <= bus.in_data[1];
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
            if (r_idx == 4'd15) begin
              r_state <= S_HDR;
              r_idx   <= 4'd0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        endcase
      end
    end
  end

  // Word 15 bypasses the buffer and goes straight into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 14; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else if (w_word_xfer && (r_state == S_BODY) && (r_idx != 4'd15)) begin
      r_buf[r_idx] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_raw        <= 96'd0;
      for (int i = 0; i < 8; i++) begin
        r_gpr[i] <= 32'd0;
      end
      r_h1w        <= 1'b0;
      r_h2w        <= 1'b0;
      r_h1a        <= 32'd0;
      r_h1d        <= 32'd0;
      r_h2a        <= 32'd0;
      r_h2d        <= 32'd0;
      r_step_count <= 32'd0;
    end else begin
      if (w_load) begin
        r_raw <= {r_buf[1], r_buf[2], r_buf[3]};
        for (int i = 0; i < 8; i++) begin
          r_gpr[i] <= r_buf[i + 4];
        end
        r_h1w <= r_h1w_asm;
        r_h2w <= r_h2w_asm;
        r_h1a <= r_buf[12];
        r_h1d <= r_buf[13];
        r_h2a <= r_buf[14];
        r_h2d <= bus.in_data;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_rec_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_rec_xfer) begin
        r_step_count <= r_step_count + 32'd1;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.raw_instr      = r_raw;
  assign bus.eax            = r_gpr[0];
  assign bus.ebx            = r_gpr[1];
  assign bus.ecx            = r_gpr[2];
  assign bus.edx            = r_gpr[3];
  assign bus.esi            = r_gpr[4];
  assign bus.edi            = r_gpr[5];
  assign bus.esp            = r_gpr[6];
  assign bus.ebp            = r_gpr[7];
  assign bus.hint1_is_write = r_h1w;
  assign bus.hint2_is_write = r_h2w;
  assign bus.hint1_address  = r_h1a;
  assign bus.hint1_data     = r_h1d;
  assign bus.hint2_address  = r_h2a;
  assign bus.hint2_data     = r_h2d;
  assign bus.err            = r_err;
  assign bus.step_count     = r_step_count;

endmodule

// File: tb/tb_trace_step_loader.sv
// Scoreboard bench for trace_step_loader: frames push expected records,
// a negedge monitor pops and compares on every record transfer.
module tb_trace_step_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_step_loader_if bus();

  trace_step_loader #(.MAGIC(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [31:0] frame_t [16];

  typedef struct packed {
    logic [95:0]      raw;
    logic [7:0][31:0] gpr;
    logic             h1w;
    logic             h2w;
    logic [31:0]      h1a;
    logic [31:0]      h1d;
    logic [31:0]      h2a;
    logic [31:0]      h2d;
  } rec_t;

  rec_t expQ[$];
  int   nChecks = 0;
  int   nPass = 0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic rec_t mkExp(frame_t f);
    rec_t r;
    r.raw = {f[1], f[2], f[3]};
    for (int i = 0; i < 8; i++) r.gpr[i] = f[4 + i];
    r.h1w = f[0][0];
    r.h2w = f[0][1];
    r.h1a = f[12];
    r.h1d = f[13];
    r.h2a = f[14];
    r.h2d = f[15];
    return r;
  endfunction

  function automatic frame_t mkFrame(logic [31:0] hdr, logic [15:0] seed);
    frame_t f;
    f[0] = hdr;
    for (int k = 1; k < 16; k++) f[k] = {seed, 8'hC0, 8'(k)};
    return f;
  endfunction

  task automatic checkOutput(input rec_t e);
    logic [31:0] act [8];
    string       nm  [8];
    act = '{bus.eax, bus.ebx, bus.ecx, bus.edx, bus.esi, bus.edi, bus.esp, bus.ebp};
    nm  = '{"eax", "ebx", "ecx", "edx", "esi", "edi", "esp", "ebp"};
    check("raw_instr", bus.raw_instr, e.raw);
    for (int i = 0; i < 8; i++) check(nm[i], act[i], e.gpr[i]);
    check("hint1_is_write", bus.hint1_is_write, e.h1w);
    check("hint2_is_write", bus.hint2_is_write, e.h2w);
    check("hint1_address", bus.hint1_address, e.h1a);
    check("hint1_data", bus.hint1_data, e.h1d);
    check("hint2_address", bus.hint2_address, e.h2a);
    check("hint2_data", bus.hint2_data, e.h2d);
  endtask

  // Monitor: every record handed to decode must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        check("unexpected_record", 1, 0);
      end else begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      else stalls++;
      @(posedge clk);
      #1;
      if (!done && stalls > 200) begin
        check("word_accept_timeout", 0, 1);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sendFrame(input frame_t f, input int nWords, input bit gaps,
                           input bit checkIdx, output int earlyStalls, output int lastStall);
    int s;
    int g;
    earlyStalls = 0;
    lastStall = 0;
    if (nWords == 16) expQ.push_back(mkExp(f));
    for (int k = 0; k < nWords; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        if (checkIdx) check($sformatf("idx_hold_w%0d", k), dut.r_idx, k);
      end
      applyStimulus(f[k], s);
      if (k == 15) lastStall = s;
      else earlyStalls += s;
      if (checkIdx) check($sformatf("idx_after_w%0d", k), dut.r_idx, (k == 15) ? 0 : k + 1);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_step_count", bus.step_count, 0);
    check("rst_raw_instr", bus.raw_instr, 0);
    check("rst_eax", bus.eax, 0);
    check("rst_hint2_data", bus.hint2_data, 0);
    check("rst_idx", dut.r_idx, 0);
    expQ.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_t f1, fa, fb, fc, fx, fy, fz;
    int es, ls, es2, ls2;
    rec_t ea, eb;

    f1 = '{32'hA5000001, 32'h01D80000, 32'h0, 32'h0,
           32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
           32'h1000, 32'hDEAD, 32'h2000, 32'hBEEF};
    fa = mkFrame(32'hA5000002, 16'hAAAA);
    fb = mkFrame(32'hA5000003, 16'hBBBB);
    fc = mkFrame(32'hA5000000, 16'hCCCC);
    fx = mkFrame(32'hA5000003, 16'h7777);
    fy = mkFrame(32'hA5000001, 16'h1234);
    fz = mkFrame(32'hA5000002, 16'h5150);
    bus.out_ready = 1'b1;

    // Clean frame with decode always ready.
    resetDut();
    sendFrame(f1, 16, 0, 0, es, ls);
    check("t1_no_stalls", es + ls, 0);
    @(negedge clk);
    check("t1_out_valid_hi", bus.out_valid, 1);
    @(negedge clk);
    check("t1_out_valid_lo", bus.out_valid, 0);
    check("t1_step_count", bus.step_count, 1);

    // Back-pressure: frame A held while frame B stalls on its last word.
    resetDut();
    bus.out_ready = 1'b0;
    ea = mkExp(fa);
    eb = mkExp(fb);
    sendFrame(fa, 16, 0, 0, es, ls);
    check("t2_a_no_stalls", es + ls, 0);
    fork
      sendFrame(fb, 16, 0, 0, es2, ls2);
      begin
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
          @(negedge clk);
          n++;
          if (bus.in_valid && !bus.in_ready) seen = 1;
        end
        check("t2_stall_seen", seen, 1);
        check("t2_held_raw", bus.raw_instr, ea.raw);
        check("t2_held_eax", bus.eax, ea.gpr[0]);
        check("t2_held_hint2_data", bus.hint2_data, ea.h2d);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("t2_valid_kept", bus.out_valid, 1);
        check("t2_step_count_1", bus.step_count, 1);
        check("t2_b_raw_loaded", bus.raw_instr, eb.raw);
        check("t2_b_ebp_loaded", bus.ebp, eb.gpr[7]);
      end
    join
    check("t2_b_early_stalls", es2, 0);
    check("t2_b_last_stalled", (ls2 >= 1), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_step_count_2", bus.step_count, 2);
    check("t2_drained", bus.out_valid, 0);

    // Malformed headers are dropped and flagged; the next frame still aligns.
    resetDut();
    applyStimulus(32'h5A000000, es);
    check("t3_err_after_magic", bus.err, 1);
    check("t3_idx_after_magic", dut.r_idx, 0);
    applyStimulus(32'hA5000004, es);
    check("t3_idx_after_rsvd", dut.r_idx, 0);
    sendFrame(fc, 16, 0, 0, es, ls);
    repeat (2) @(negedge clk);
    check("t3_err_sticky", bus.err, 1);
    check("t3_step_count", bus.step_count, 1);

    // Reset mid-frame discards the partial frame.
    resetDut();
    sendFrame(fx, 8, 0, 0, es, ls);
    resetDut();
    sendFrame(fy, 16, 0, 0, es, ls);
    repeat (2) @(negedge clk);
    check("t4_step_count", bus.step_count, 1);

    // Step counter wrap through the internal hook.
    resetDut();
    bus.out_ready = 1'b0;
    sendFrame(fz, 16, 0, 0, es, ls);
    @(negedge clk);
    check("t5_pending", bus.out_valid, 1);
    force dut.r_step_count = 32'hFFFFFFFF;
    #1;
    release dut.r_step_count;
    check("t5_preset", bus.step_count, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("t5_wrapped", bus.step_count, 0);
    check("t5_valid_cleared", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // Idle gaps between words must not disturb the record or the index.
    resetDut();
    sendFrame(f1, 16, 1, 1, es, ls);
    repeat (3) @(negedge clk);
    check("t6_step_count", bus.step_count, 1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
